// File: rtl/nexus_block_alloc_ctrl.sv
// Nexus SRAM block allocator: circular free list, per-tenant quotas, pointer-table writes.
// Optional double-free checker enabled by defining NEXUS_ALLOC_DFREE_CHK_EN.
module nexus_block_alloc_ctrl #(
   parameter int SRAM_BLOCKS   = 1024,
   parameter int ADW           = 10,
   parameter int TENANTS       = 16,
   parameter int TID_W         = 4,
   parameter int BKT_W         = 8,
   parameter int DEFAULT_QUOTA = 64
) (
   input  logic             i_clk,
   input  logic             i_arst_n,
   output logic             o_init_done,
   input  logic             i_alloc_valid,
   output logic             o_alloc_ready,
   input  logic [BKT_W-1:0] i_alloc_bucket,
   input  logic [TID_W-1:0] i_alloc_tenant,
   input  logic             i_free_valid,
   output logic             o_free_ready,
   input  logic [ADW-1:0]   i_free_addr,
   input  logic [TID_W-1:0] i_free_tenant,
   output logic             o_rsp_valid,
   output logic             o_rsp_ok,
   output logic [ADW-1:0]   o_rsp_addr,
   output logic             o_pt_we,
   output logic [BKT_W-1:0] o_pt_bucket,
   output logic [ADW-1:0]   o_pt_addr,
   input  logic             i_cfg_we,
   input  logic [TID_W-1:0] i_cfg_tenant,
   input  logic [ADW:0]     i_cfg_quota,
   output logic [ADW:0]     o_free_count
`ifdef NEXUS_ALLOC_DFREE_CHK_EN
   ,
   output logic             o_dfree_err
`endif
);

   typedef enum logic {S_INIT, S_RUN} state_t;

   localparam logic [ADW:0]   FULL  = (ADW+1)'(SRAM_BLOCKS);
   localparam logic [ADW-1:0] LAST  = ADW'(SRAM_BLOCKS - 1);
   localparam logic [ADW:0]   DQUOT = (ADW+1)'(DEFAULT_QUOTA);

   state_t           state_q, state_d;
   logic [ADW-1:0]   head_q, head_d;
   logic [ADW-1:0]   tail_q, tail_d;
   logic [ADW:0]     count_q, count_d;
   logic [ADW:0]     usage_q [TENANTS];
   logic [ADW:0]     usage_d [TENANTS];
   logic [ADW:0]     quota_q [TENANTS];
   logic [ADW:0]     quota_d [TENANTS];
   logic             rr_q, rr_d;
   logic             init_done_q, init_done_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_ok_q, rsp_ok_d;
   logic [ADW-1:0]   rsp_addr_q, rsp_addr_d;
   logic             pt_we_q, pt_we_d;
   logic [BKT_W-1:0] pt_bucket_q, pt_bucket_d;
   logic [ADW-1:0]   pt_addr_q, pt_addr_d;
`ifdef NEXUS_ALLOC_DFREE_CHK_EN
   logic [SRAM_BLOCKS-1:0] bitmap_q, bitmap_d;
   logic                   dfree_q, dfree_d;
`endif

   logic [ADW-1:0] fifo_q [SRAM_BLOCKS];
   logic           fifo_we;
   logic [ADW-1:0] fifo_waddr;
   logic [ADW-1:0] fifo_wdata;
   logic [ADW-1:0] pop_addr;
   logic           run;
   logic           grant;
   logic           free_ok;

   // rr_q == 0 means the next conflict goes to the free side
   assign run           = (state_q == S_RUN);
   assign o_free_ready  = run & i_free_valid & (~i_alloc_valid | ~rr_q);
   assign o_alloc_ready = run & i_alloc_valid & (~i_free_valid | rr_q);
   assign pop_addr      = fifo_q[head_q];

   always_comb begin
      state_d     = state_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      usage_d     = usage_q;
      quota_d     = quota_q;
      rr_d        = rr_q;
      init_done_d = init_done_q;
      rsp_valid_d = 1'b0;
      rsp_ok_d    = 1'b0;
      rsp_addr_d  = '0;
      pt_we_d     = 1'b0;
      pt_bucket_d = '0;
      pt_addr_d   = '0;
      fifo_we     = 1'b0;
      fifo_waddr  = tail_q;
      fifo_wdata  = i_free_addr;
      grant       = 1'b0;
      free_ok     = 1'b0;
`ifdef NEXUS_ALLOC_DFREE_CHK_EN
      bitmap_d    = bitmap_q;
      dfree_d     = 1'b0;
`endif
      unique case (state_q)
         S_INIT: begin
            fifo_we    = 1'b1;
            fifo_wdata = tail_q;
            tail_d     = tail_q + 1'b1;
            if (tail_q == LAST) begin
               count_d     = FULL;
               init_done_d = 1'b1;
               state_d     = S_RUN;
            end
         end
         S_RUN: begin
            if (i_alloc_valid && i_free_valid) begin
               rr_d = ~rr_q;
            end
            if (o_alloc_ready) begin
               grant = (count_q != '0) &&
                       (usage_q[i_alloc_tenant] < quota_q[i_alloc_tenant]);
               rsp_valid_d = 1'b1;
               if (grant) begin
                  rsp_ok_d    = 1'b1;
                  rsp_addr_d  = pop_addr;
                  pt_we_d     = 1'b1;
                  pt_bucket_d = i_alloc_bucket;
                  pt_addr_d   = pop_addr;
                  head_d      = head_q + 1'b1;
                  count_d     = count_q - 1'b1;
                  usage_d[i_alloc_tenant] = usage_q[i_alloc_tenant] + 1'b1;
`ifdef NEXUS_ALLOC_DFREE_CHK_EN
                  bitmap_d[pop_addr] = 1'b1;
`endif
               end
            end
            if (o_free_ready) begin
               free_ok = (count_q != FULL);
`ifdef NEXUS_ALLOC_DFREE_CHK_EN
               if (!bitmap_q[i_free_addr]) begin
                  free_ok = 1'b0;
                  dfree_d = 1'b1;
               end
`endif
               if (free_ok) begin
                  fifo_we = 1'b1;
                  tail_d  = tail_q + 1'b1;
                  count_d = count_q + 1'b1;
                  if (usage_q[i_free_tenant] != '0) begin
                     usage_d[i_free_tenant] = usage_q[i_free_tenant] - 1'b1;
                  end
`ifdef NEXUS_ALLOC_DFREE_CHK_EN
                  bitmap_d[i_free_addr] = 1'b0;
`endif
               end
            end
         end
         default: state_d = S_INIT;
      endcase
      // quota writes land after this cycle's alloc check
      if (i_cfg_we) begin
         quota_d[i_cfg_tenant] = i_cfg_quota;
      end
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q     <= S_INIT;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         rr_q        <= 1'b0;
         init_done_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_ok_q    <= 1'b0;
         rsp_addr_q  <= '0;
         pt_we_q     <= 1'b0;
         pt_bucket_q <= '0;
         pt_addr_q   <= '0;
         for (int i = 0; i < TENANTS; i++) begin
            usage_q[i] <= '0;
            quota_q[i] <= DQUOT;
         end
`ifdef NEXUS_ALLOC_DFREE_CHK_EN
         bitmap_q    <= '0;
         dfree_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         rr_q        <= rr_d;
         init_done_q <= init_done_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_ok_q    <= rsp_ok_d;
         rsp_addr_q  <= rsp_addr_d;
         pt_we_q     <= pt_we_d;
         pt_bucket_q <= pt_bucket_d;
         pt_addr_q   <= pt_addr_d;
         usage_q     <= usage_d;
         quota_q     <= quota_d;
`ifdef NEXUS_ALLOC_DFREE_CHK_EN
         bitmap_q    <= bitmap_d;
         dfree_q     <= dfree_d;
`endif
      end
   end

   // free-list storage is rewritten by INIT, so it needs no reset
   always_ff @(posedge i_clk) begin
      if (fifo_we) begin
         fifo_q[fifo_waddr] <= fifo_wdata;
      end
   end

   assign o_init_done  = init_done_q;
   assign o_rsp_valid  = rsp_valid_q;
   assign o_rsp_ok     = rsp_ok_q;
   assign o_rsp_addr   = rsp_addr_q;
   assign o_pt_we      = pt_we_q;
   assign o_pt_bucket  = pt_bucket_q;
   assign o_pt_addr    = pt_addr_q;
   assign o_free_count = count_q;
`ifdef NEXUS_ALLOC_DFREE_CHK_EN
   assign o_dfree_err  = dfree_q;
`endif

endmodule

// File: doc/nexus_block_alloc_ctrl.md
Name: nexus_block_alloc_ctrl

Overview:
Owns the pool of physical SRAM blocks that back the Nexus PIFO buckets and hands them to tenants elastically.
- Keeps a circular free list of block addresses and per-tenant usage counters with programmable quotas.
- Arbitrates between alloc and free requesters.
- On each successful alloc, emits a write into the bucket-to-address pointer table.

Parameters:
SRAM_BLOCKS, 1024, number of physical blocks; power of two.
ADW, 10, block address width, log2(SRAM_BLOCKS).
TENANTS, 16, number of tenants.
TID_W, 4, tenant id width.
BKT_W, 8, bucket id width.
DEFAULT_QUOTA, 64, per-tenant quota loaded at reset; width ADW+1.

Ports:
i_clk  in  1  clock.
i_arst_n  in  1  async reset, active-low.
o_init_done  out  1  high once the free list is populated.
i_alloc_valid  in  1  alloc request valid.
o_alloc_ready  out  1  alloc request accepted this cycle.
i_alloc_bucket  in  BKT_W  bucket to map.
i_alloc_tenant  in  TID_W  requesting tenant.
i_free_valid  in  1  free request valid.
o_free_ready  out  1  free request accepted this cycle.
i_free_addr  in  ADW  block being returned.
i_free_tenant  in  TID_W  owning tenant.
o_rsp_valid  out  1  alloc response strobe.
o_rsp_ok  out  1  1 = granted, 0 = denied.
o_rsp_addr  out  ADW  granted block; 0 when denied.
o_pt_we  out  1  pointer table write enable.
o_pt_bucket  out  BKT_W  pointer table index.
o_pt_addr  out  ADW  pointer table data.
i_cfg_we  in  1  quota write.
i_cfg_tenant  in  TID_W  quota target.
i_cfg_quota  in  ADW+1  new quota.
o_free_count  out  ADW+1  blocks currently in the free list.

Reset and clocking:
- Reset i_arst_n, asynchronous, active-low; clock i_clk.
- Reset values: all outputs 0; head=tail=0; free count 0; usage counters 0; quotas DEFAULT_QUOTA; FSM=INIT.

State machine:
- INIT
  - Writes fifo[k]=k for k=0..SRAM_BLOCKS-1, one entry per cycle.
  - After the last write: count=SRAM_BLOCKS, tail wraps to 0, o_init_done=1 (sticky), go to RUN.
  - INIT takes exactly SRAM_BLOCKS cycles.
  - Both readies are 0 during INIT.
- RUN
  - At most one operation per cycle, alloc or free.

Arbitration:
- Only one of alloc/free valid: that one is granted.
- Both valid: round-robin by a 1-bit pointer that flips after each both-valid conflict; first conflict after reset goes to free.
- Readies are combinational from valid + FSM + pointer. The loser sees ready=0 and must hold its request.

Alloc, accepted at cycle T; response at T+1:
- Granted when count>0 and usage[tenant]<quota[tenant].
  - Pop fifo[head]; head+1 mod SRAM_BLOCKS; count−1; usage[tenant]+1.
  - o_rsp_valid=1, o_rsp_ok=1, o_rsp_addr=block.
  - o_pt_we=1 with o_pt_bucket/o_pt_addr in the same cycle.
- Denied when count==0 or usage==quota.
  - o_rsp_valid=1, o_rsp_ok=0, o_rsp_addr=0, no pt write, state unchanged.
- Accept/deny is decided at cycle T from pre-update state.

Free, accepted at T:
- Push i_free_addr at tail; tail+1 mod SRAM_BLOCKS; count+1; usage[tenant]−1. All updates visible at T+1.
- No response strobe.
- usage==0 on free: usage saturates at 0; the block is still pushed.
- Free when count==SRAM_BLOCKS: dropped, no state change.

Quota config:
- i_cfg_we takes effect the next cycle; allowed in any state.
- Lowering a quota below current usage is legal; new allocs for that tenant are denied until usage<quota.
- Same-cycle cfg write and alloc for the same tenant: alloc is checked against the old quota.

Other:
- o_free_count is registered and equals count.
- Reset mid-operation: everything returns to reset values and INIT restarts; in-flight responses are lost.

Optional Feature:
NEXUS_ALLOC_DFREE_CHK_EN
- Enabled:
  - Adds an SRAM_BLOCKS-bit ownership bitmap: set on grant, cleared on free; all zero at reset.
  - Free of a block whose bit is 0 is ignored (no push, usage unchanged) and raises output o_dfree_err (1 bit) for one cycle at T+1.
- Disabled: no bitmap and no o_dfree_err port; frees are trusted.

Test Plan:
1. Reset, idle → o_init_done rises after exactly 1024 cycles; o_free_count=1024; readies 0 beforehand.
2. Tenant 3 allocs bucket 5 then bucket 6 → rsp addr 0 then 1, ok=1; pt writes (5,0) and (6,1); free_count=1022.
3. Quota of tenant 2 set to 2; three allocs → third gets ok=0, addr 0, no pt write; free block 0 for tenant 2, retry → ok=1, addr 2.
4. Alloc and free valid together for 4 cycles → grants go free, alloc, free, alloc.
5. Allocate all 1024 blocks (quotas raised to 1024) → next alloc ok=0; free addr 7 → next alloc returns 7 (ring wrap).
6. With NEXUS_ALLOC_DFREE_CHK_EN: free addr 9 that was never allocated → o_dfree_err pulses once; free_count unchanged.
